// File: rtl/fetch_sequencer_if.sv
// Bundle of PC, control and memory signals around the fetch sequencer.
// The slave modport is the sequencer; master is the PC/control/memory side.
interface fetch_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] pc_in;
  logic              pc_write;
  logic [DATA_W-1:0] pc_next;
  logic              fetch_start;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_target;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              busy;
  logic              fetch_err;

  modport slave (
    input  pc_in, fetch_start, redirect_valid, redirect_target, mem_ack, mem_rdata,
    output pc_write, pc_next, mem_req, mem_addr, instr, instr_valid, busy, fetch_err
  );

  modport master (
    output pc_in, fetch_start, redirect_valid, redirect_target, mem_ack, mem_rdata,
    input  pc_write, pc_next, mem_req, mem_addr, instr, instr_valid, busy, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch: reads PC, fetches one word over req/ack,
// writes the next PC (sequential or redirected) and loads RESET_PC after reset.
module fetch_sequencer #(
  parameter int                DATA_W   = 16,
  parameter int                PC_INC   = 2,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic CLK,
  input  logic RST_N,
  fetch_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_REQ,
    S_UPDATE
  } state_t;

  state_t            state_q, state_d;
  logic              pc_write_q, pc_write_d;
  logic [DATA_W-1:0] pc_next_q, pc_next_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              busy_q, busy_d;
  logic              fetch_err_q, fetch_err_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_INIT;
      pc_write_q    <= 1'b0;
      pc_next_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b1;
      fetch_err_q   <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_tgt_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_write_q    <= pc_write_d;
      pc_next_q     <= pc_next_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      fetch_err_q   <= fetch_err_d;
      pend_vld_q    <= pend_vld_d;
      pend_tgt_q    <= pend_tgt_d;
      cnt_q         <= cnt_d;
    end
  end

  // Outputs are registered: the _d values computed here appear on the bus
  // in the same cycle the FSM enters state_d.
  always_comb begin
    state_d       = state_q;
    pc_write_d    = 1'b0;
    pc_next_d     = pc_next_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fetch_err_d   = fetch_err_q;
    pend_vld_d    = pend_vld_q;
    pend_tgt_d    = pend_tgt_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_INIT: begin
        pc_write_d = 1'b1;
        pc_next_d  = RESET_PC;
        state_d    = S_IDLE;
      end
      S_IDLE: begin
        // A redirect takes priority; a coincident fetch_start is dropped.
        if (bus.redirect_valid) begin
          pc_write_d = 1'b1;
          pc_next_d  = bus.redirect_target;
        end else if (bus.fetch_start) begin
          mem_addr_d  = bus.pc_in;
          mem_req_d   = 1'b1;
          fetch_err_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect_valid) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = bus.redirect_target;
        end
        if (bus.mem_ack) begin
          instr_d       = bus.mem_rdata;
          mem_req_d     = 1'b0;
          instr_valid_d = 1'b1;
          pc_write_d    = 1'b1;
          if (bus.redirect_valid)  pc_next_d = bus.redirect_target;
          else if (pend_vld_q)     pc_next_d = pend_tgt_q;
          else                     pc_next_d = mem_addr_q + DATA_W'(PC_INC);
          pend_vld_d    = 1'b0;
          state_d       = S_UPDATE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          pend_vld_d  = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UPDATE: begin
        // A redirect arriving during the write cycle follows up immediately.
        if (bus.redirect_valid) begin
          pc_write_d = 1'b1;
          pc_next_d  = bus.redirect_target;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.pc_write    = pc_write_q;
  assign bus.pc_next     = pc_next_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.busy        = busy_q;
  assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, fetch, wait states, wrap,
// redirects, timeout and reset during an outstanding request.
module tb_fetch_sequencer;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  fetch_sequencer_if #(.DATA_W(16)) bus ();

  fetch_sequencer #(
    .DATA_W(16), .PC_INC(2), .RESET_PC(16'h0000), .TIMEOUT(15)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pc_in           = '0;
    bus.fetch_start     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.mem_ack         = 1'b0;
    bus.mem_rdata       = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    clear_inputs();
    tick(); tick();
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got %0h exp 0", bus.pc_write); end
    checks++; if (bus.pc_next !== 16'h0000) begin errors++; $display("FAIL rst_pc_next got %h exp 0000", bus.pc_next); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h exp 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got %h exp 0000", bus.mem_addr); end
    checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h exp 0000", bus.instr); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %0h exp 0", bus.instr_valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0h exp 1", bus.busy); end
    checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL rst_fetch_err got %0h exp 0", bus.fetch_err); end
    RST_N = 1'b1;
    tick();
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL init_pc_write got %0h exp 1", bus.pc_write); end
    checks++; if (bus.pc_next !== 16'h0000) begin errors++; $display("FAIL init_pc_next got %h exp 0000", bus.pc_next); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL init_busy got %0h exp 0", bus.busy); end
    tick();
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL init_single_pulse got %0h exp 0", bus.pc_write); end
  endtask

  task automatic test_basic_fetch();
    bus.pc_in = 16'h0010; bus.fetch_start = 1'b1;
    tick();
    bus.fetch_start = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %0h exp 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL basic_addr got %h exp 0010", bus.mem_addr); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0h exp 1", bus.busy); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA5C3;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL basic_instr_valid got %0h exp 1", bus.instr_valid); end
    checks++; if (bus.instr !== 16'hA5C3) begin errors++; $display("FAIL basic_instr got %h exp a5c3", bus.instr); end
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL basic_pc_write got %0h exp 1", bus.pc_write); end
    checks++; if (bus.pc_next !== 16'h0012) begin errors++; $display("FAIL basic_pc_next got %h exp 0012", bus.pc_next); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %0h exp 0", bus.mem_req); end
    tick();
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc_write !== 1'b0) begin errors++; $display("FAIL basic_pulse_end got %0h%0h exp 00", bus.instr_valid, bus.pc_write); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %0h exp 0", bus.busy); end
  endtask

  task automatic test_wait_wrap();
    int held;
    held = 0;
    bus.pc_in = 16'hFFFE; bus.fetch_start = 1'b1;
    tick();
    bus.fetch_start = 1'b0;
    bus.pc_in = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr === 16'hFFFE) held++;
      tick();
    end
    if (bus.mem_req === 1'b1 && bus.mem_addr === 16'hFFFE) held++;
    checks++; if (held !== 4) begin errors++; $display("FAIL wait_req_held got %0d exp 4", held); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.pc_next !== 16'h0000) begin errors++; $display("FAIL wrap_pc_next got %h exp 0000", bus.pc_next); end
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL wrap_pc_write got %0h exp 1", bus.pc_write); end
    checks++; if (bus.instr !== 16'h1234) begin errors++; $display("FAIL wrap_instr got %h exp 1234", bus.instr); end
    tick();
  endtask

  task automatic test_redirect();
    bus.pc_in = 16'h0020; bus.fetch_start = 1'b1;
    tick();
    bus.fetch_start = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_target = 16'h0200;
    tick();
    bus.redirect_target = 16'h0100;
    tick();
    bus.redirect_valid = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.pc_next !== 16'h0100) begin errors++; $display("FAIL redir_busy_pc_next got %h exp 0100", bus.pc_next); end
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL redir_busy_pc_write got %0h exp 1", bus.pc_write); end
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_target = 16'h0100;
    bus.fetch_start = 1'b1; bus.pc_in = 16'h0030;
    tick();
    bus.redirect_valid = 1'b0; bus.fetch_start = 1'b0;
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL redir_idle_pc_write got %0h exp 1", bus.pc_write); end
    checks++; if (bus.pc_next !== 16'h0100) begin errors++; $display("FAIL redir_idle_pc_next got %h exp 0100", bus.pc_next); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL redir_idle_no_req got %0h exp 0", bus.mem_req); end
    tick();
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL redir_fetch_dropped got %0h%0h exp 00", bus.mem_req, bus.busy); end
  endtask

  task automatic test_timeout();
    int req_cycles;
    int pw_seen;
    int n;
    req_cycles = 0; pw_seen = 0; n = 0;
    bus.pc_in = 16'h0040; bus.fetch_start = 1'b1;
    tick();
    bus.fetch_start = 1'b0;
    while (bus.mem_req === 1'b1 && n < 40) begin
      req_cycles++;
      if (bus.pc_write === 1'b1) pw_seen++;
      n++;
      tick();
    end
    if (bus.pc_write === 1'b1) pw_seen++;
    checks++; if (req_cycles !== 15) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 15", req_cycles); end
    checks++; if (bus.fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %0h exp 1", bus.fetch_err); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req got %0h exp 0", bus.mem_req); end
    checks++; if (pw_seen !== 0) begin errors++; $display("FAIL timeout_no_pc_write got %0d exp 0", pw_seen); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr === 16'hDEAD) begin errors++; $display("FAIL stray_ack got valid %0h instr %h exp 0 and not dead", bus.instr_valid, bus.instr); end
    checks++; if (bus.fetch_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0h exp 1", bus.fetch_err); end
    bus.pc_in = 16'h0050; bus.fetch_start = 1'b1;
    tick();
    bus.fetch_start = 1'b0;
    checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0h exp 0", bus.fetch_err); end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL err_refetch_req got %0h exp 1", bus.mem_req); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0F0F;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.pc_next !== 16'h0052) begin errors++; $display("FAIL refetch_pc_next got %h exp 0052", bus.pc_next); end
    tick();
  endtask

  task automatic test_reset_midfetch();
    bus.pc_in = 16'h0060; bus.fetch_start = 1'b1;
    tick();
    bus.fetch_start = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL midrst_req_pre got %0h exp 1", bus.mem_req); end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req_async got %0h exp 0", bus.mem_req); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %0h exp 1", bus.busy); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc_write !== 1'b0) begin errors++; $display("FAIL midrst_no_valid got %0h%0h exp 00", bus.instr_valid, bus.pc_write); end
    RST_N = 1'b1;
    tick();
    checks++; if (bus.pc_write !== 1'b1 || bus.pc_next !== 16'h0000) begin errors++; $display("FAIL midrst_init got pw %0h pc %h exp 1 0000", bus.pc_write, bus.pc_next); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy %0h req %0h exp 0 0", bus.busy, bus.mem_req); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N  = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_fetch();
    test_wait_wrap();
    test_redirect();
    test_timeout();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
